// File: rtl/dist_3b_3output.sv
// dist_3b_3output: registered 1-to-3 distributor that steers a value into one of
// three valid/ready holding registers. Define DIST_DROPCNT_EN for the drop counter.
module dist_3b_3output #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Op,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [WIDTH-1:0] OutC,
  output logic             ValidA,
  output logic             ValidB,
  output logic             ValidC,
  input  logic             ReadyA,
  input  logic             ReadyB,
  input  logic             ReadyC,
  output logic             Err,
  input  logic             Err_clr,
  output logic [CNT_W-1:0] Drop_count
);

  logic [2:0]       ready;
  logic [2:0]       valid_q;
  logic [2:0]       load;
  logic [WIDTH-1:0] out_q [3];
  logic             accept;
  logic             drop;
  logic             err_q;

  assign ready = {ReadyC, ReadyB, ReadyA};

  // A channel can take new data when empty or being drained this same cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    In_ready = 1'b1;
    case (Op)
      2'd0:    In_ready = !valid_q[0] || ready[0];
      2'd1:    In_ready = !valid_q[1] || ready[1];
      2'd2:    In_ready = !valid_q[2] || ready[2];
      default: In_ready = 1'b1;
    endcase
  end

  assign accept = In_valid && In_ready;
  assign drop   = accept && (Op == 2'd3);

  always_comb begin
    load = '0;
    case (Op)
      2'd0:    load[0] = accept;
      2'd1:    load[1] = accept;
      2'd2:    load[2] = accept;
      default: load    = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: only three small holding registers, so they are reset to give defined outputs.
      for (int i = 0; i < 3; i++) out_q[i] <= '0;
      valid_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (load[i]) begin
          out_q[i]   <= In;
          valid_q[i] <= 1'b1;
        end else if (valid_q[i] && ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Setting on a dropped transfer takes priority over a simultaneous clear.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)     err_q <= 1'b0;
    else if (drop)    err_q <= 1'b1;
    else if (Err_clr) err_q <= 1'b0;
  end

`ifdef DIST_DROPCNT_EN
  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)                 drop_q <= '0;
    else if (drop && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
  end

  assign Drop_count = drop_q;
`else
  assign Drop_count = '0;
`endif

  assign OutA   = out_q[0];
  assign OutB   = out_q[1];
  assign OutC   = out_q[2];
  assign ValidA = valid_q[0];
  assign ValidB = valid_q[1];
  assign ValidC = valid_q[2];
  assign Err    = err_q;

endmodule

// File: tb/tb_dist_3b_3output.sv
// Self-checking bench for dist_3b_3output: a per-channel behavioural model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dist_3b_3output;

  localparam int WIDTH = 3;
  localparam int CNT_W = 4;
`ifdef DIST_DROPCNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             Reset_n = 1'b0;
  logic [WIDTH-1:0] In = '0;
  logic [1:0]       Op = '0;
  logic             In_valid = 1'b0;
  logic             In_ready;
  logic [WIDTH-1:0] OutA, OutB, OutC;
  logic             ValidA, ValidB, ValidC;
  logic             ReadyA = 1'b0, ReadyB = 1'b0, ReadyC = 1'b0;
  logic             Err;
  logic             Err_clr = 1'b0;
  logic [CNT_W-1:0] Drop_count;

  int checks = 0;
  int errors = 0;

  dist_3b_3output #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .In(In), .Op(Op), .In_valid(In_valid),
    .In_ready(In_ready), .OutA(OutA), .OutB(OutB), .OutC(OutC),
    .ValidA(ValidA), .ValidB(ValidB), .ValidC(ValidC),
    .ReadyA(ReadyA), .ReadyB(ReadyB), .ReadyC(ReadyC),
    .Err(Err), .Err_clr(Err_clr), .Drop_count(Drop_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: each destination is a one-entry buffer.
  int m_data  [3];
  bit m_full  [3];
  bit m_err;
  int m_drops;

  function automatic bit consumer_ready(input int ch);
    case (ch)
      0:       return ReadyA;
      1:       return ReadyB;
      default: return ReadyC;
    endcase
  endfunction

  function automatic bit model_in_ready(input int op);
    if (op == 3) return 1'b1;
    return !m_full[op] || consumer_ready(op);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_data[i] = 0;
      m_full[i] = 1'b0;
    end
    m_err   = 1'b0;
    m_drops = 0;
  endtask

  initial model_clear();

  always @(negedge Reset_n) model_clear();

  always @(posedge CLK) begin
    if (!Reset_n) begin
      model_clear();
    end else begin
      int  op;
      bit  acc;
      bit  rdy [3];
      op  = int'(Op);
      acc = In_valid && model_in_ready(op);
      for (int i = 0; i < 3; i++) rdy[i] = consumer_ready(i);
      if (acc && op == 3) begin
        m_err = 1'b1;
        if (DROP_EN && m_drops < DROP_MAX) m_drops++;
      end else if (Err_clr) begin
        m_err = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (acc && op == i) begin
          m_data[i] = int'(In);
          m_full[i] = 1'b1;
        end else if (m_full[i] && rdy[i]) begin
          m_full[i] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    check("model_OutA", int'(OutA), m_data[0]);
    check("model_OutB", int'(OutB), m_data[1]);
    check("model_OutC", int'(OutC), m_data[2]);
    check("model_ValidA", int'(ValidA), int'(m_full[0]));
    check("model_ValidB", int'(ValidB), int'(m_full[1]));
    check("model_ValidC", int'(ValidC), int'(m_full[2]));
    check("model_Err", int'(Err), int'(m_err));
    check("model_Drop_count", int'(Drop_count), m_drops);
    check("model_In_ready", int'(In_ready), int'(model_in_ready(int'(Op))));
  end

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs: everything idle.
    Reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      In = WIDTH'($urandom); Op = 2'($urandom); In_valid = 1'($urandom);
      ReadyA = 1'($urandom); ReadyB = 1'($urandom); ReadyC = 1'($urandom);
      Err_clr = 1'($urandom);
      cyc();
    end
    check("rst_OutA", int'(OutA), 0);
    check("rst_OutB", int'(OutB), 0);
    check("rst_OutC", int'(OutC), 0);
    check("rst_Valid", int'({ValidA, ValidB, ValidC}), 0);
    check("rst_Err", int'(Err), 0);
    check("rst_Drop_count", int'(Drop_count), 0);
    for (int op = 0; op < 4; op++) begin
      Op = 2'(op);
      #1;
      check("rst_In_ready", int'(In_ready), 1);
    end
    In = '0; Op = '0; In_valid = 1'b0; Err_clr = 1'b0;
    ReadyA = 1'b0; ReadyB = 1'b0; ReadyC = 1'b0;
    Reset_n = 1'b1;
    cyc();

    // Single route to B, hold, then drain.
    In = 3'd5; Op = 2'd1; In_valid = 1'b1;
    cyc();
    In_valid = 1'b0;
    check("route_OutB", int'(OutB), 5);
    check("route_ValidB", int'(ValidB), 1);
    check("route_ValidA", int'(ValidA), 0);
    check("route_ValidC", int'(ValidC), 0);
    repeat (10) cyc();
    check("hold_OutB", int'(OutB), 5);
    check("hold_ValidB", int'(ValidB), 1);
    ReadyB = 1'b1;
    cyc();
    ReadyB = 1'b0;
    check("drain_ValidB", int'(ValidB), 0);
    check("drain_OutB_kept", int'(OutB), 5);

    // Backpressure on A must not block C.
    In = 3'd4; Op = 2'd0; In_valid = 1'b1;
    cyc();
    In = 3'd3;
    #1;
    check("bp_In_ready_A", int'(In_ready), 0);
    cyc();
    check("bp_OutA_held", int'(OutA), 4);
    check("bp_ValidA_held", int'(ValidA), 1);
    In = 3'd6; Op = 2'd2;
    #1;
    check("indep_In_ready_C", int'(In_ready), 1);
    cyc();
    In_valid = 1'b0;
    check("indep_OutC", int'(OutC), 6);
    check("indep_ValidC", int'(ValidC), 1);
    check("indep_OutA", int'(OutA), 4);

    // Streaming into C with the consumer always ready.
    ReadyC = 1'b1; Op = 2'd2;
    for (int v = 1; v <= 4; v++) begin
      In = WIDTH'(v); In_valid = 1'b1;
      #1;
      check("stream_In_ready", int'(In_ready), 1);
      cyc();
      check("stream_OutC", int'(OutC), v);
      check("stream_ValidC", int'(ValidC), 1);
    end
    In_valid = 1'b0;
    cyc();
    check("stream_end_ValidC", int'(ValidC), 0);
    ReadyC = 1'b0;
    ReadyA = 1'b1;
    cyc();
    ReadyA = 1'b0;
    check("drainA_ValidA", int'(ValidA), 0);

    // Illegal select for 20 cycles; clear pulse in cycle 5 loses to the set.
    In = 3'd7; Op = 2'd3; In_valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      Err_clr = (c == 5);
      cyc();
      check("illegal_Err", int'(Err), 1);
      check("illegal_Valid", int'({ValidA, ValidB, ValidC}), 0);
      if (c == 3)  check("illegal_Drop_3", int'(Drop_count), DROP_EN ? 3 : 0);
      if (c == 15) check("illegal_Drop_15", int'(Drop_count), DROP_EN ? 15 : 0);
      if (c == 20) check("illegal_Drop_sat", int'(Drop_count), DROP_EN ? 15 : 0);
    end
    In_valid = 1'b0; Err_clr = 1'b0;
    check("illegal_OutA_kept", int'(OutA), 4);

    // Err_clr alone clears Err; the drop count is unaffected.
    Err_clr = 1'b1;
    cyc();
    Err_clr = 1'b0;
    check("errclr_Err", int'(Err), 0);
    check("errclr_Drop", int'(Drop_count), DROP_EN ? 15 : 0);

    // Mid-operation asynchronous reset between clock edges.
    In = 3'd1; Op = 2'd0; In_valid = 1'b1;
    cyc();
    In = 3'd2; Op = 2'd1;
    cyc();
    In = 3'd3; Op = 2'd3;
    cyc();
    In_valid = 1'b0;
    check("pre_rst_Valid", int'({ValidA, ValidB}), 3);
    check("pre_rst_Err", int'(Err), 1);
    #1;
    Reset_n = 1'b0;
    #1;
    check("async_Valid", int'({ValidA, ValidB, ValidC}), 0);
    check("async_Err", int'(Err), 0);
    check("async_OutA", int'(OutA), 0);
    check("async_OutB", int'(OutB), 0);
    check("async_Drop", int'(Drop_count), 0);
    #1;
    Reset_n = 1'b1;
    cyc();
    In = 3'd2; Op = 2'd0; In_valid = 1'b1;
    cyc();
    In_valid = 1'b0;
    check("post_rst_OutA", int'(OutA), 2);
    check("post_rst_ValidA", int'(ValidA), 1);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dist_3b_3output.md
Name: dist_3b_3output

Overview:
- Registered 1-to-3 distributor for 3-bit datapath values; the write-side counterpart of the 3-input 3-bit select mux.
- A single upstream producer presents a value plus a 2-bit destination select (Op).
- The block steers the value into one of three per-destination holding registers, each with its own valid/ready handshake.
- Sits between the control unit's writeback/route stage and the three destination consumers (A, B, C).

Parameters:
- WIDTH, 3, data width of In and of each Out_x.
- CNT_W, 4, width of the drop counter; used only with DIST_DROPCNT_EN.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- In  input  WIDTH  value to distribute.
- Op  input  2  destination select: 0=A, 1=B, 2=C, 3=illegal.
- In_valid  input  1  upstream has a value on In/Op.
- In_ready  output  1  block accepts In/Op this cycle.
- OutA, OutB, OutC  output  WIDTH  holding-register contents for each destination.
- ValidA, ValidB, ValidC  output  1  holding register x holds undelivered data.
- ReadyA, ReadyB, ReadyC  input  1  destination x consumes data this cycle.
- Err  output  1  sticky flag; set when an Op==3 transfer is accepted.
- Err_clr  input  1  synchronous clear of Err.
- Drop_count  output  CNT_W  number of dropped Op==3 transfers (see Optional Feature).

Behaviour:
- Reset (Reset_n low, async): OutA/B/C=0, ValidA/B/C=0, Err=0, Drop_count=0. Any pending data is discarded; no partial transfers survive reset.
- In_ready is combinational:
  - Op==0: !ValidA | ReadyA.
  - Op==1: !ValidB | ReadyB.
  - Op==2: !ValidC | ReadyC.
  - Op==3: 1.
  - In_ready is independent of In_valid.
- Accept = In_valid & In_ready.
- Per channel x, each clock:
  - Accept & Op==x: Out_x <= In, Valid_x <= 1. This covers simultaneous drain and refill, which must give back-to-back throughput of one per cycle per channel.
  - Otherwise, Valid_x & Ready_x: Valid_x <= 0. Out_x keeps its last value; it is not cleared.
  - Otherwise: hold.
- Latency: an accepted value appears on Out_x with Valid_x high the cycle after acceptance.
- Stability: while Valid_x=1 and Ready_x=0, Out_x and Valid_x must not change.
- Ready_x while Valid_x=0 has no effect.
- Channels are independent: a stalled channel never blocks acceptance for another channel.
- Op==3 accepted:
  - Data is dropped; no channel changes.
  - Err <= 1.
  - If Err_clr is high in the same cycle, the set wins and Err=1.
- Err_clr alone: Err <= 0 next cycle.
- In_valid low: no state change except drains.
- Op/In changes while In_valid=0 are ignored.

Optional Feature:
- Macro: DIST_DROPCNT_EN.
- Defined:
  - Drop_count increments by 1 on each accepted Op==3 transfer.
  - Saturates at 2^CNT_W-1 (15 by default); no wrap.
  - Not affected by Err_clr; cleared only by reset.
- Undefined: Drop_count is tied to 0 and no counter flops are synthesized. The port list is unchanged.

Test Plan:
- Reset then idle: Reset_n=0 with random inputs -> all Out=0, all Valid=0, Err=0, Drop_count=0. In_ready=1 for every Op.
- Single route: In=5, Op=1, In_valid=1 for one cycle, ReadyB=0 -> next cycle OutB=5, ValidB=1; ValidA=ValidC=0. Holds for 10 cycles. ReadyB=1 for one cycle -> ValidB=0, OutB still 5.
- Backpressure and independence: ValidA=1 with ReadyA=0. Present In=3, Op=0 -> In_ready=0 and OutA unchanged. Present In=6, Op=2 -> In_ready=1, and next cycle OutC=6, ValidC=1.
- Streaming: ReadyC=1 held, Op=2, In=1,2,3,4 on consecutive cycles -> In_ready=1 every cycle, and OutC=1,2,3,4 on consecutive cycles with ValidC continuously 1.
- Illegal select: Op=3, In=7, In_valid=1 for 20 cycles with Err_clr pulsed in cycle 5 -> no Valid rises, and Err stays 1. With DIST_DROPCNT_EN, Drop_count=15 after cycle 15 and stays 15; without it, Drop_count=0.
- Reset mid-operation: ValidA=1, ValidB=1, Err=1, then Reset_n pulsed low for less than 1 cycle between edges -> all cleared immediately (async); the next accepted In=2, Op=0 gives OutA=2, ValidA=1.
